mem_instr_dispatcher: RTL and testbench

- Consumer end of the control unit's memory-instruction interface.
- Accepts each packed superscalar memory-instruction bundle (lane 0 carries absolute addr/stride values, lanes 1..N-1 carry deltas) plus its copy_count, and buffers bundles in a FIFO.
- Expands each bundle into per-lane absolute micro-ops: lane k value = base + k*delta.
- Issues micro-ops one per cycle to the memory APU over a valid/ready handshake, and drives back-pressure (queue_full) to the control unit.

---
 rtl/mem_instr_dispatcher.sv | 250 +++++++++++++++++++++++++
 tb/tb_mem_instr_dispatcher.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_instr_dispatcher.sv
// Purpose : buffers packed superscalar memory-instruction bundles and expands each into per-lane absolute micro-ops.
// Latency : a bundle pushed at edge N is presented with apu_valid=1 going into edge N+2 (pop into issue registers at N+1).
// Backpressure: apu_ready=0 freezes all apu_* outputs; queue_full (registered) tells the producer the FIFO holds DEPTH bundles.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   memory_instructions     SW lanes of {op[14:0], addr, stridex, stridey}, lane 0 in the MSBs.
//                           Lane 0 carries absolute values, lane 1 carries per-lane deltas.
//   copy_count              active lanes minus one for the pushed bundle
//   memory_instruction_we   push strobe; ignored (and flagged) while queue_full=1
//   queue_full              FIFO holds DEPTH bundles
//   overflow_error          sticky: a push arrived while full, bundle dropped
//   apu_valid / apu_ready   micro-op handshake to the memory APU
//   apu_op, apu_addr, apu_stridex, apu_stridey, apu_lane, apu_last   micro-op payload
//   stall_cycles            (only with MEM_DISPATCH_PERF_EN) saturating count of valid&&!ready cycles
//   idle                    FIFO empty and nothing being issued
//
// Optional feature macro: MEM_DISPATCH_PERF_EN adds the stall_cycles output and its counter.
module mem_instr_dispatcher #(
    parameter int MEMORY_ADDRESS_BITS   = 15,
    parameter int SUPERSCALAR_LOG_WIDTH = 2,
    parameter int QUEUE_LOG_DEPTH       = 2,
    localparam int MAB      = MEMORY_ADDRESS_BITS,
    localparam int SLW      = SUPERSCALAR_LOG_WIDTH,
    localparam int SW       = 1 << SUPERSCALAR_LOG_WIDTH,
    localparam int LANE_W   = 15 + 3 * MEMORY_ADDRESS_BITS,
    localparam int BUNDLE_W = LANE_W * SW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BUNDLE_W-1:0] memory_instructions,
    input  logic [SLW-1:0]      copy_count,
    input  logic                memory_instruction_we,
    output logic                queue_full,
    output logic                overflow_error,
    output logic                apu_valid,
    input  logic                apu_ready,
    output logic [14:0]         apu_op,
    output logic [MAB-1:0]      apu_addr,
    output logic [MAB-1:0]      apu_stridex,
    output logic [MAB-1:0]      apu_stridey,
    output logic [SLW-1:0]      apu_lane,
    output logic                apu_last,
`ifdef MEM_DISPATCH_PERF_EN
    output logic [31:0]         stall_cycles,
`endif
    output logic                idle
);

    localparam int QLD   = QUEUE_LOG_DEPTH;
    localparam int DEPTH = 1 << QUEUE_LOG_DEPTH;
    localparam logic [QLD:0] FULL_COUNT = (QLD + 1)'(DEPTH);

    // Only lane 0 (bases) and lane 1 (deltas) are needed to rebuild every lane,
    // so that is all a queue entry keeps.
    typedef struct packed {
        logic [14:0]    op;
        logic [MAB-1:0] addr;
        logic [MAB-1:0] stridex;
        logic [MAB-1:0] stridey;
        logic [MAB-1:0] daddr;
        logic [MAB-1:0] dstridex;
        logic [MAB-1:0] dstridey;
        logic [SLW-1:0] last_lane;
    } entry_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    // ------------------------------------------------------------------
    // Bundle unpacking
    // ------------------------------------------------------------------
    logic [LANE_W-1:0] lane0_dat;
    logic [LANE_W-1:0] lane1_dat;
    entry_t            push_entry;

    assign lane0_dat = memory_instructions[BUNDLE_W-1 -: LANE_W];
    assign lane1_dat = memory_instructions[BUNDLE_W-LANE_W-1 -: LANE_W];

    always_comb begin
        push_entry           = '0;
        push_entry.op        = lane0_dat[LANE_W-1 -: 15];
        push_entry.addr      = lane0_dat[3*MAB-1 -: MAB];
        push_entry.stridex   = lane0_dat[2*MAB-1 -: MAB];
        push_entry.stridey   = lane0_dat[MAB-1:0];
        push_entry.daddr     = lane1_dat[3*MAB-1 -: MAB];
        push_entry.dstridex  = lane1_dat[2*MAB-1 -: MAB];
        push_entry.dstridey  = lane1_dat[MAB-1:0];
        push_entry.last_lane = copy_count;
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    entry_t          fifo_mem [DEPTH];
    logic [QLD-1:0]  wr_ptr_q;
    logic [QLD-1:0]  rd_ptr_q;
    logic [QLD:0]    count_q;
    logic [QLD:0]    count_d;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    entry_t          head;

    // Push qualification uses the registered full flag, so a pop in the
    // same cycle never makes room for a push that arrived while full.
    assign push       = memory_instruction_we && !queue_full;
    assign fifo_empty = (count_q == '0);
    assign head       = fifo_mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            queue_full     <= 1'b0;
            overflow_error <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            queue_full <= (count_d == FULL_COUNT);
            if (memory_instruction_we && queue_full) begin
                overflow_error <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    state_t         state_q;
    state_t         state_d;
    logic           advance;
    logic [14:0]    op_q;
    logic [MAB-1:0] cur_addr_q;
    logic [MAB-1:0] cur_stridex_q;
    logic [MAB-1:0] cur_stridey_q;
    logic [MAB-1:0] daddr_q;
    logic [MAB-1:0] dstridex_q;
    logic [MAB-1:0] dstridey_q;
    logic [SLW-1:0] last_lane_q;
    logic [SLW-1:0] lane_q;
    logic           on_last_lane;

    assign on_last_lane = (lane_q == last_lane_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (apu_ready) begin
                    if (!on_last_lane) begin
                        advance = 1'b1;
                    end else if (!fifo_empty) begin
                        // Load the next bundle on the final handshake: no bubble.
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Working registers only move on pop or on an accepted non-last lane,
    // which is what keeps the payload stable under apu_ready=0.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q          <= '0;
            cur_addr_q    <= '0;
            cur_stridex_q <= '0;
            cur_stridey_q <= '0;
            daddr_q       <= '0;
            dstridex_q    <= '0;
            dstridey_q    <= '0;
            last_lane_q   <= '0;
            lane_q        <= '0;
        end else if (pop) begin
            op_q          <= head.op;
            cur_addr_q    <= head.addr;
            cur_stridex_q <= head.stridex;
            cur_stridey_q <= head.stridey;
            daddr_q       <= head.daddr;
            dstridex_q    <= head.dstridex;
            dstridey_q    <= head.dstridey;
            last_lane_q   <= head.last_lane;
            lane_q        <= '0;
        end else if (advance) begin
            lane_q        <= lane_q + 1'b1;
            cur_addr_q    <= cur_addr_q + daddr_q;
            cur_stridex_q <= cur_stridex_q + dstridex_q;
            cur_stridey_q <= cur_stridey_q + dstridey_q;
        end
    end

    assign apu_valid   = (state_q == ISSUE);
    assign apu_last    = apu_valid && on_last_lane;
    assign apu_op      = op_q;
    assign apu_addr    = cur_addr_q;
    assign apu_stridex = cur_stridex_q;
    assign apu_stridey = cur_stridey_q;
    assign apu_lane    = lane_q;
    assign idle        = fifo_empty && (state_q == IDLE);

`ifdef MEM_DISPATCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (apu_valid && !apu_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_instr_dispatcher.sv
module tb_mem_instr_dispatcher;

    localparam int MAB = 15;
    localparam int SLW = 2;
    localparam int SW  = 4;
    localparam int LW  = 15 + 3 * MAB;
    localparam int BW  = LW * SW;

    logic           clk = 1'b0;
    logic           reset;
    logic [BW-1:0]  memory_instructions;
    logic [SLW-1:0] copy_count;
    logic           memory_instruction_we;
    logic           queue_full;
    logic           overflow_error;
    logic           apu_valid;
    logic           apu_ready;
    logic [14:0]    apu_op;
    logic [MAB-1:0] apu_addr;
    logic [MAB-1:0] apu_stridex;
    logic [MAB-1:0] apu_stridey;
    logic [SLW-1:0] apu_lane;
    logic           apu_last;
    logic           idle;
`ifdef MEM_DISPATCH_PERF_EN
    logic [31:0]    stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_instr_dispatcher #(
        .MEMORY_ADDRESS_BITS  (MAB),
        .SUPERSCALAR_LOG_WIDTH(SLW),
        .QUEUE_LOG_DEPTH      (2)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .memory_instructions  (memory_instructions),
        .copy_count           (copy_count),
        .memory_instruction_we(memory_instruction_we),
        .queue_full           (queue_full),
        .overflow_error       (overflow_error),
        .apu_valid            (apu_valid),
        .apu_ready            (apu_ready),
        .apu_op               (apu_op),
        .apu_addr             (apu_addr),
        .apu_stridex          (apu_stridex),
        .apu_stridey          (apu_stridey),
        .apu_lane             (apu_lane),
        .apu_last             (apu_last),
`ifdef MEM_DISPATCH_PERF_EN
        .stall_cycles         (stall_cycles),
`endif
        .idle                 (idle)
    );

    // Lane 0 = bases, lane 1 = deltas, lanes 2/3 filled with junk that must never surface.
    function automatic logic [BW-1:0] mk(input logic [14:0] op,
                                          input logic [MAB-1:0] a, input logic [MAB-1:0] x,
                                          input logic [MAB-1:0] y, input logic [MAB-1:0] da,
                                          input logic [MAB-1:0] dx, input logic [MAB-1:0] dy);
        logic [BW-1:0] b;
        b = '0;
        b[BW-1 -: LW]    = {op, a, x, y};
        b[BW-LW-1 -: LW] = {15'h7FFF, da, dx, dy};
        b[2*LW-1:0]      = {2{15'h5555, 15'h2AAA, 15'h1555, 15'h0F0F}};
        return b;
    endfunction

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [BW-1:0] b, input logic [SLW-1:0] cc);
        memory_instructions   = b;
        copy_count            = cc;
        memory_instruction_we = 1'b1;
        tick();
        memory_instruction_we = 1'b0;
    endtask

    task automatic do_reset();
        reset                 = 1'b1;
        memory_instruction_we = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset                 = 1'b1;
        memory_instructions   = '0;
        copy_count            = '0;
        memory_instruction_we = 1'b0;
        apu_ready             = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({queue_full, overflow_error, apu_valid, apu_last} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: full/ovf/valid/last got %b expected 0000",
                     {queue_full, overflow_error, apu_valid, apu_last});
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 1", idle);
        end
        checks++;
        if ({apu_op, apu_addr, apu_stridex, apu_stridey, apu_lane} !== '0) begin
            errors++;
            $display("FAIL reset_data: op=%h addr=%h sx=%h sy=%h lane=%0d expected all 0",
                     apu_op, apu_addr, apu_stridex, apu_stridey, apu_lane);
        end
`ifdef MEM_DISPATCH_PERF_EN
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_stall: got %0d expected 0", stall_cycles);
        end
`endif
    endtask

    task automatic test_single();
        apu_ready = 1'b1;
        push1(mk(15'h1234, 15'd100, 15'd4, 15'd8, 15'd9, 15'd9, 15'd9), 2'd0);
        // Push captured; FSM pops on the following edge.
        checks++;
        if (apu_valid !== 1'b0 || idle !== 1'b0) begin
            errors++;
            $display("FAIL single_latency1: valid=%b idle=%b expected valid=0 idle=0", apu_valid, idle);
        end
        tick();
        checks++;
        if ({apu_valid, apu_op, apu_addr, apu_stridex, apu_stridey, apu_lane, apu_last}
            !== {1'b1, 15'h1234, 15'd100, 15'd4, 15'd8, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL single_uop: valid=%b op=%h addr=%0d sx=%0d sy=%0d lane=%0d last=%b expected 1 1234 100 4 8 0 1",
                     apu_valid, apu_op, apu_addr, apu_stridex, apu_stridey, apu_lane, apu_last);
        end
        tick();
        checks++;
        if (apu_valid !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL single_done: valid=%b idle=%b expected valid=0 idle=1", apu_valid, idle);
        end
    endtask

    task automatic test_expand();
        apu_ready = 1'b1;
        push1(mk(15'h0042, 15'd100, 15'd4, 15'd8, 15'd16, 15'd1, 15'd2), 2'd3);
        tick();
        for (int k = 0; k < 4; k++) begin
            logic [MAB-1:0] ea;
            logic [MAB-1:0] ex;
            logic [MAB-1:0] ey;
            logic           el;
            ea = 15'(100 + 16 * k);
            ex = 15'(4 + k);
            ey = 15'(8 + 2 * k);
            el = (k == 3);
            checks++;
            if ({apu_valid, apu_op, apu_addr, apu_stridex, apu_stridey, apu_lane, apu_last}
                !== {1'b1, 15'h0042, ea, ex, ey, 2'(k), el}) begin
                errors++;
                $display("FAIL expand_lane%0d: valid=%b addr=%0d sx=%0d sy=%0d lane=%0d last=%b expected 1 %0d %0d %0d %0d %b",
                         k, apu_valid, apu_addr, apu_stridex, apu_stridey, apu_lane, apu_last,
                         ea, ex, ey, k, el);
            end
            tick();
        end
        checks++;
        if (apu_valid !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL expand_done: valid=%b idle=%b expected valid=0 idle=1", apu_valid, idle);
        end
    endtask

    task automatic test_wrap_stall();
        do_reset();
        apu_ready = 1'b1;
        push1(mk(15'h0007, 15'h7FF0, 15'd3, 15'd5, 15'h0020, 15'd1, 15'd1), 2'd1);
        tick();
        checks++;
        if (apu_valid !== 1'b1 || apu_addr !== 15'h7FF0 || apu_lane !== 2'd0) begin
            errors++;
            $display("FAIL wrap_lane0: valid=%b addr=%h lane=%0d expected 1 7ff0 0", apu_valid, apu_addr, apu_lane);
        end
        tick();
        apu_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            // i=0 is the first presentation of lane 1, i=1..3 are the held stall cycles.
            checks++;
            if ({apu_valid, apu_addr, apu_stridex, apu_stridey, apu_lane, apu_last}
                !== {1'b1, 15'h0010, 15'd4, 15'd6, 2'd1, 1'b1}) begin
                errors++;
                $display("FAIL wrap_hold%0d: valid=%b addr=%h sx=%0d sy=%0d lane=%0d last=%b expected 1 0010 4 6 1 1",
                         i, apu_valid, apu_addr, apu_stridex, apu_stridey, apu_lane, apu_last);
            end
            if (i < 3) tick();
        end
`ifdef MEM_DISPATCH_PERF_EN
        checks++;
        if (stall_cycles !== 32'd3) begin
            errors++;
            $display("FAIL wrap_stall_cycles: got %0d expected 3", stall_cycles);
        end
`endif
        apu_ready = 1'b1;
        tick();
        checks++;
        if (apu_valid !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL wrap_done: valid=%b idle=%b expected valid=0 idle=1", apu_valid, idle);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        apu_ready = 1'b0;
        // The first bundle moves straight into the issue registers, so the
        // 4-entry FIFO becomes full on the 5th push.
        for (int i = 0; i < 5; i++) begin
            memory_instructions   = mk(15'h0011, 15'(10 * (i + 1)), 15'd0, 15'd0, 15'd0, 15'd0, 15'd0);
            copy_count            = 2'd0;
            memory_instruction_we = 1'b1;
            tick();
            checks++;
            if (queue_full !== (i == 4) || overflow_error !== 1'b0) begin
                errors++;
                $display("FAIL ovf_fill%0d: full=%b ovf=%b expected full=%b ovf=0",
                         i, queue_full, overflow_error, (i == 4));
            end
        end
        checks++;
        if (apu_valid !== 1'b1 || apu_addr !== 15'd10) begin
            errors++;
            $display("FAIL ovf_head: valid=%b addr=%0d expected 1 10", apu_valid, apu_addr);
        end
        // Push while full together with a pop: the push is still dropped.
        memory_instructions = mk(15'h0011, 15'd60, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0);
        apu_ready           = 1'b1;
        tick();
        memory_instruction_we = 1'b0;
        checks++;
        if (overflow_error !== 1'b1 || queue_full !== 1'b0 || apu_addr !== 15'd20 || apu_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drop: ovf=%b full=%b valid=%b addr=%0d expected 1 0 1 20",
                     overflow_error, queue_full, apu_valid, apu_addr);
        end
        for (int i = 2; i < 5; i++) begin
            tick();
            checks++;
            if (apu_valid !== 1'b1 || apu_addr !== 15'(10 * (i + 1)) || apu_last !== 1'b1) begin
                errors++;
                $display("FAIL ovf_drain%0d: valid=%b addr=%0d last=%b expected 1 %0d 1",
                         i, apu_valid, apu_addr, apu_last, 10 * (i + 1));
            end
        end
        tick();
        checks++;
        if (apu_valid !== 1'b0 || idle !== 1'b1 || overflow_error !== 1'b1) begin
            errors++;
            $display("FAIL ovf_done: valid=%b idle=%b ovf=%b expected 0 1 1", apu_valid, idle, overflow_error);
        end
    endtask

    task automatic test_back_to_back();
        logic [MAB-1:0] exp_addr [4];
        logic [MAB-1:0] exp_sx   [4];
        exp_addr = '{15'd200, 15'd201, 15'd500, 15'd503};
        exp_sx   = '{15'd7, 15'd9, 15'd1, 15'd1};
        do_reset();
        apu_ready = 1'b0;
        push1(mk(15'h00A0, 15'd200, 15'd7, 15'd0, 15'd1, 15'd2, 15'd0), 2'd1);
        push1(mk(15'h00B0, 15'd500, 15'd1, 15'd0, 15'd3, 15'd0, 15'd0), 2'd1);
        apu_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [14:0] eop;
            eop = (k < 2) ? 15'h00A0 : 15'h00B0;
            checks++;
            if ({apu_valid, apu_op, apu_addr, apu_stridex, apu_lane, apu_last}
                !== {1'b1, eop, exp_addr[k], exp_sx[k], 2'(k % 2), (k % 2 == 1)}) begin
                errors++;
                $display("FAIL b2b_uop%0d: valid=%b op=%h addr=%0d sx=%0d lane=%0d last=%b expected 1 %h %0d %0d %0d %b",
                         k, apu_valid, apu_op, apu_addr, apu_stridex, apu_lane, apu_last,
                         eop, exp_addr[k], exp_sx[k], k % 2, (k % 2 == 1));
            end
            tick();
        end
        checks++;
        if (apu_valid !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: valid=%b idle=%b expected valid=0 idle=1", apu_valid, idle);
        end
    endtask

    task automatic test_reset_mid_issue();
        do_reset();
        apu_ready             = 1'b0;
        memory_instructions   = mk(15'h0033, 15'd1000, 15'd0, 15'd0, 15'd10, 15'd0, 15'd0);
        copy_count            = 2'd3;
        memory_instruction_we = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        memory_instruction_we = 1'b0;
        checks++;
        if (overflow_error !== 1'b1 || queue_full !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: ovf=%b full=%b expected 1 1", overflow_error, queue_full);
        end
        apu_ready = 1'b1;
        tick();
        checks++;
        if (apu_valid !== 1'b1 || apu_lane !== 2'd1 || apu_addr !== 15'd1010) begin
            errors++;
            $display("FAIL mid_lane1: valid=%b lane=%0d addr=%0d expected 1 1 1010", apu_valid, apu_lane, apu_addr);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({apu_valid, idle, queue_full, overflow_error, apu_lane} !== {1'b0, 1'b1, 1'b0, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL mid_reset: valid=%b idle=%b full=%b ovf=%b lane=%0d expected 0 1 0 0 0",
                     apu_valid, idle, queue_full, overflow_error, apu_lane);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (apu_valid !== 1'b0 || idle !== 1'b1) begin
                errors++;
                $display("FAIL mid_after%0d: valid=%b idle=%b expected valid=0 idle=1", i, apu_valid, idle);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_expand();
        test_wrap_stall();
        test_overflow();
        test_back_to_back();
        test_reset_mid_issue();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
